// File: rtl/popcount_enum_pkg.sv
// Shared types and helpers for the popcount_enum word enumerator.
package popcount_enum_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 16;

  // Mask with the k most significant bits of a width-bit word set.
  function automatic logic [MAX_WIDTH-1:0] top_k_mask(input int width, input int k);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      m[i] = (i < width) && (i >= width - k);
    end
    return m;
  endfunction

endpackage

// File: rtl/popcount_chk.sv
// Combinational popcount used by the optional output self-check.
module popcount_chk #(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [KW-1:0]    count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + KW'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcount_enum.sv
// Enumerates every WIDTH-bit word of popcount k in ascending order (Gosper's hack).
// Define POPCOUNT_ENUM_SELFCHECK_EN to build the sticky popcount/ordering checker on err.
module popcount_enum
  import popcount_enum_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             cmd_valid,
  input  logic [KW-1:0]    cmd_k,
  output logic             cmd_ready,
  output logic [WIDTH-1:0] O,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_bad,
  input  logic             out_ready,
  output logic             err
);

  localparam logic [KW-1:0] K_MAX = KW'(WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     o_q, o_d;
  logic                 last_q, last_d;
  logic                 bad_q, bad_d;
  logic [KW-1:0]        k_q, k_d;

  logic                 accept, xfer;
  logic [WIDTH:0]       x, c, r, nxt;
  logic [4:0]           ctz;
  logic [WIDTH-1:0]     low_mask;
  logic [MAX_WIDTH-1:0] tm_run, tm_cmd;
  logic                 unused_bits;

  assign cmd_ready = (state_q == IDLE);
  assign out_valid = (state_q == RUN);
  assign O         = o_q;
  assign out_last  = last_q;
  assign out_bad   = bad_q;
  assign accept    = cmd_valid && cmd_ready;
  assign xfer      = out_valid && out_ready;

  // Arithmetic carries one spare bit so the ripple out of the top never wraps.
  always_comb begin
    x   = {1'b0, o_q};
    c   = x & (-x);
    r   = x + c;
    ctz = '0;
    for (int i = WIDTH; i >= 0; i--) begin
      if (c[i]) ctz = 5'(i);
    end
    nxt = (((r ^ x) >> 2) >> ctz) | r;
  end

  always_comb begin
    low_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low_mask[i] = (i < int'(cmd_k));
    end
    tm_run = top_k_mask(WIDTH, int'(k_q));
    tm_cmd = top_k_mask(WIDTH, int'(cmd_k));
  end

  assign unused_bits = ^{nxt[WIDTH], tm_run, tm_cmd};

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    last_d  = last_q;
    bad_d   = bad_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = RUN;
          k_d     = cmd_k;
          if (cmd_k > K_MAX) begin
            o_d    = '0;
            last_d = 1'b1;
            bad_d  = 1'b1;
          end else begin
            o_d    = low_mask;
            last_d = (low_mask == tm_cmd[WIDTH-1:0]);
            bad_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            o_d    = nxt[WIDTH-1:0];
            last_d = (nxt[WIDTH-1:0] == tm_run[WIDTH-1:0]);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= IDLE;
      o_q     <= '0;
      last_q  <= 1'b0;
      bad_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      last_q  <= last_d;
      bad_q   <= bad_d;
      k_q     <= k_d;
    end
  end

`ifdef POPCOUNT_ENUM_SELFCHECK_EN
  logic [KW-1:0]    pc;
  logic [WIDTH-1:0] prev_q;
  logic             have_prev_q;
  logic             err_q;

  popcount_chk #(.WIDTH(WIDTH), .KW(KW)) u_chk (
    .data_i  (o_q),
    .count_o (pc)
  );

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      have_prev_q <= 1'b0;
    end else if (xfer && !bad_q) begin
      if ((pc != k_q) || (have_prev_q && (o_q <= prev_q))) err_q <= 1'b1;
      prev_q      <= o_q;
      have_prev_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_enum.sv
// Directed bench for popcount_enum (WIDTH=8) with per-scenario checking tasks.
module tb_popcount_enum;

  localparam int W  = 8;
  localparam int KW = 4;

  logic          CLK = 1'b0;
  logic          ASYNCRESET = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [KW-1:0] cmd_k = '0;
  logic          cmd_ready;
  logic [W-1:0]  O;
  logic          out_valid, out_last, out_bad;
  logic          out_ready = 1'b0;
  logic          err;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] got_o[$];
  bit           got_last[$];
  bit           got_bad[$];
  logic [W-1:0] exp_o[$];
  logic         after_valid, after_ready;

  always #5 CLK = ~CLK;

  popcount_enum #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .cmd_valid  (cmd_valid),
    .cmd_k      (cmd_k),
    .cmd_ready  (cmd_ready),
    .O          (O),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_bad    (out_bad),
    .out_ready  (out_ready),
    .err        (err)
  );

  // Reference word list by brute force over all 256 words.
  function automatic void build_exp(input int k);
    exp_o.delete();
    for (int v = 0; v < 256; v++) begin
      if ($countones(v) == k) exp_o.push_back(W'(v));
    end
  endfunction

  task automatic issue(input int k);
    cmd_valid = 1'b1;
    cmd_k     = KW'(k);
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_k     = KW'(k + 5);
  endtask

  task automatic collect(input bit bp, output int nb, output bit timeout, output int stall_viol);
    bit           stalled;
    bit           rdy;
    logic [W-1:0] held_o;
    logic         held_l, held_b;
    got_o.delete(); got_last.delete(); got_bad.delete();
    nb = 0; timeout = 1'b1; stall_viol = 0; stalled = 1'b0;
    held_o = '0; held_l = 1'b0; held_b = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (out_valid) begin
        if (stalled && (O !== held_o || out_last !== held_l || out_bad !== held_b)) stall_viol++;
        rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = rdy;
        if (rdy) begin
          got_o.push_back(O); got_last.push_back(out_last); got_bad.push_back(out_bad);
          nb++;
          stalled = 1'b0;
          if (out_last) begin
            @(negedge CLK);
            out_ready   = 1'b0;
            after_valid = out_valid;
            after_ready = cmd_ready;
            timeout     = 1'b0;
            break;
          end
        end else begin
          stalled = 1'b1; held_o = O; held_l = out_last; held_b = out_bad;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge CLK);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 ASYNCRESET = 1'b1;
    repeat (2) @(negedge CLK);
    vectors++;
    if ({out_valid, O, out_last, out_bad, err} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_held: valid=%b O=%h last=%b bad=%b err=%b, expected all zero",
               out_valid, O, out_last, out_bad, err);
    end
    ASYNCRESET = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({cmd_ready, out_valid, O, out_last, out_bad, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b valid=%b O=%h last=%b bad=%b err=%b, expected ready=1 rest 0",
               cmd_ready, out_valid, O, out_last, out_bad, err);
    end
  endtask

  task automatic test_k1();
    int nb, sv; bit to;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL k1_ready: cmd_ready=%b, expected 1", cmd_ready);
    end
    issue(1);
    vectors++;
    if ({out_valid, O} !== {1'b1, 8'h01}) begin
      miscompares++; $display("FAIL k1_latency: valid=%b O=%h, expected valid=1 O=01", out_valid, O);
    end
    collect(1'b0, nb, to, sv);
    build_exp(1);
    vectors++;
    if (to || nb != exp_o.size()) begin
      miscompares++; $display("FAIL k1_count: beats=%0d timeout=%b, expected %0d", nb, to, exp_o.size());
    end
    for (int i = 0; i < nb && i < exp_o.size(); i++) begin
      vectors++;
      if ({got_o[i], got_last[i], got_bad[i]} !== {exp_o[i], i == exp_o.size() - 1, 1'b0}) begin
        miscompares++;
        $display("FAIL k1_beat[%0d]: O=%h last=%b bad=%b, expected O=%h last=%b bad=0",
                 i, got_o[i], got_last[i], got_bad[i], exp_o[i], i == exp_o.size() - 1);
      end
    end
    vectors++;
    if ({after_valid, after_ready} !== 2'b01) begin
      miscompares++; $display("FAIL k1_after: valid=%b ready=%b, expected valid=0 ready=1", after_valid, after_ready);
    end
  endtask

  task automatic test_k4_backpressure();
    int nb, sv; bit to;
    issue(4);
    collect(1'b1, nb, to, sv);
    build_exp(4);
    vectors++;
    if (to || nb != exp_o.size() || nb != 70) begin
      miscompares++; $display("FAIL k4_count: beats=%0d timeout=%b, expected 70", nb, to);
    end
    vectors++;
    if (sv != 0) begin
      miscompares++; $display("FAIL k4_stall_stable: %0d changes while stalled, expected 0", sv);
    end
    for (int i = 0; i < nb && i < exp_o.size(); i++) begin
      vectors++;
      if ({got_o[i], got_last[i], got_bad[i]} !== {exp_o[i], i == exp_o.size() - 1, 1'b0}) begin
        miscompares++;
        $display("FAIL k4_beat[%0d]: O=%h last=%b bad=%b, expected O=%h last=%b bad=0",
                 i, got_o[i], got_last[i], got_bad[i], exp_o[i], i == exp_o.size() - 1);
      end
    end
  endtask

  task automatic test_edges();
    int nb, sv; bit to;
    int           ks   [3] = '{0, 8, 9};
    logic [W-1:0] eo   [3] = '{8'h00, 8'hFF, 8'h00};
    bit           ebad [3] = '{1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      issue(ks[t]);
      collect(1'b0, nb, to, sv);
      vectors++;
      if (to || nb != 1) begin
        miscompares++; $display("FAIL edge_k%0d_count: beats=%0d timeout=%b, expected 1", ks[t], nb, to);
      end else begin
        vectors++;
        if ({got_o[0], got_last[0], got_bad[0]} !== {eo[t], 1'b1, ebad[t]}) begin
          miscompares++;
          $display("FAIL edge_k%0d_beat: O=%h last=%b bad=%b, expected O=%h last=1 bad=%b",
                   ks[t], got_o[0], got_last[0], got_bad[0], eo[t], ebad[t]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int nb, sv; bit to;
    issue(3);
    out_ready = 1'b1;
    repeat (5) @(negedge CLK);
    out_ready = 1'b0;
    #2 ASYNCRESET = 1'b1;
    #1;
    vectors++;
    if ({out_valid, O} !== {1'b0, 8'h00}) begin
      miscompares++; $display("FAIL rst_mid_immediate: valid=%b O=%h, expected valid=0 O=00", out_valid, O);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    ASYNCRESET = 1'b0;
    repeat (2) @(negedge CLK);
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, cmd_ready} !== 2'b01) begin
      miscompares++; $display("FAIL rst_mid_abandon: valid=%b ready=%b, expected valid=0 ready=1", out_valid, cmd_ready);
    end
    issue(2);
    collect(1'b0, nb, to, sv);
    build_exp(2);
    vectors++;
    if (to || nb != 28) begin
      miscompares++; $display("FAIL rst_mid_k2_count: beats=%0d timeout=%b, expected 28", nb, to);
    end
    for (int i = 0; i < nb && i < exp_o.size(); i++) begin
      vectors++;
      if ({got_o[i], got_last[i], got_bad[i]} !== {exp_o[i], i == exp_o.size() - 1, 1'b0}) begin
        miscompares++;
        $display("FAIL rst_mid_k2_beat[%0d]: O=%h last=%b bad=%b, expected O=%h last=%b bad=0",
                 i, got_o[i], got_last[i], got_bad[i], exp_o[i], i == exp_o.size() - 1);
      end
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL err_clean: err=%b, expected 0", err);
    end
  endtask

`ifdef POPCOUNT_ENUM_SELFCHECK_EN
  task automatic test_selfcheck();
    int nb, sv, total; bit to, any_to;
    total = 0; any_to = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      issue(k);
      collect(1'b0, nb, to, sv);
      any_to |= to;
      for (int i = 0; i < nb; i++) if (!got_bad[i]) total++;
    end
    vectors++;
    if (any_to || total != 256 || err !== 1'b0) begin
      miscompares++; $display("FAIL chk_all_k: beats=%0d err=%b timeout=%b, expected 256 err=0", total, err, any_to);
    end
    issue(4);
    force dut.o_q = 8'h03;
    out_ready = 1'b1;
    @(negedge CLK);
    release dut.o_q;
    out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++; $display("FAIL chk_corrupt_sticky: err=%b, expected 1", err);
    end
    ASYNCRESET = 1'b1;
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    @(negedge CLK);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL chk_reset_clear: err=%b, expected 0", err);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_k1();
    test_k4_backpressure();
    test_edges();
    test_reset_mid_run();
`ifdef POPCOUNT_ENUM_SELFCHECK_EN
    test_selfcheck();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
